// File: rtl/rom_fetch_ctrl_if.sv
// Fetch-side bus between the sequencer, the combinational program ROM and the
// decode/execute consumer.
interface rom_fetch_ctrl_if #(
  parameter int unsigned AW = 4,
  parameter int unsigned DW = 16
);
  logic [AW-1:0] rom_addr;
  logic [DW-1:0] rom_data;
  logic [DW-1:0] instr;
  logic [AW-1:0] instr_pc;
  logic          instr_valid;
  logic          instr_ready;
  logic          jump_valid;
  logic [AW-1:0] jump_addr;

  modport master (
    output rom_addr,
    output instr,
    output instr_pc,
    output instr_valid,
    input  rom_data,
    input  instr_ready,
    input  jump_valid,
    input  jump_addr
  );

  modport slave (
    input  rom_addr,
    input  instr,
    input  instr_pc,
    input  instr_valid,
    output rom_data,
    output instr_ready,
    output jump_valid,
    output jump_addr
  );
endinterface

// File: rtl/rom_fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, latches ROM words and issues them
// with a valid/ready handshake; accepts jump redirects and stops on HALT_WORD.
module rom_fetch_ctrl #(
  parameter int unsigned     AW        = 4,
  parameter int unsigned     DW        = 16,
  parameter logic [AW-1:0]   RESET_PC  = '0,
  parameter logic [DW-1:0]   HALT_WORD = '0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start_i,
  output logic                busy_o,
  output logic                halted_o,
  rom_fetch_ctrl_if.master    bus
);

  typedef enum logic [1:0] {StIdle, StFetch, StIssue, StHalt} state_e;

  state_e        state_q;
  logic [AW-1:0] pc_q;
  logic [DW-1:0] instr_q;
  logic [AW-1:0] instr_pc_q;
  logic          instr_valid_q;
  logic          halted_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StIdle;
      pc_q          <= '0;
      instr_q       <= '0;
      instr_pc_q    <= '0;
      instr_valid_q <= 1'b0;
      halted_q      <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start_i) begin
            pc_q    <= RESET_PC;
            state_q <= StFetch;
          end
        end
        StFetch: begin
          // pc stays on the halt word so a restart can be debugged from it
          if (bus.rom_data != HALT_WORD) begin
            instr_q       <= bus.rom_data;
            instr_pc_q    <= pc_q;
            instr_valid_q <= 1'b1;
            pc_q          <= pc_q + AW'(1);
            state_q       <= StIssue;
          end else begin
            halted_q <= 1'b1;
            state_q  <= StHalt;
          end
        end
        StIssue: begin
          if (bus.instr_ready) begin
            instr_valid_q <= 1'b0;
            state_q       <= StFetch;
            if (bus.jump_valid) begin
              pc_q <= bus.jump_addr;
            end
          end
        end
        StHalt: begin
          if (start_i) begin
            pc_q     <= RESET_PC;
            halted_q <= 1'b0;
            state_q  <= StFetch;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.rom_addr    = pc_q;
  assign bus.instr       = instr_q;
  assign bus.instr_pc    = instr_pc_q;
  assign bus.instr_valid = instr_valid_q;
  assign busy_o          = (state_q == StFetch) || (state_q == StIssue);
  assign halted_o        = halted_q;

endmodule

// File: tb/tb_rom_fetch_ctrl.sv
// Self-checking bench for rom_fetch_ctrl: cycle-by-cycle vector table plus
// scoreboarded handshake sequences against a behavioural ROM.
module tb_rom_fetch_ctrl;
  localparam int AW = 4;
  localparam int DW = 16;

  logic clk = 1'b0;
  logic rst;
  logic start;
  logic busy;
  logic halted;
  logic [DW-1:0] rom [16];

  always #5 clk = ~clk;

  rom_fetch_ctrl_if #(.AW(AW), .DW(DW)) bus ();

  assign bus.rom_data = rom[bus.rom_addr];

  rom_fetch_ctrl #(
    .AW(AW), .DW(DW), .RESET_PC(4'd0), .HALT_WORD(16'h0000)
  ) u_dut (
    .clk(clk), .rst(rst), .start_i(start), .busy_o(busy), .halted_o(halted), .bus(bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, got, exp);
    end
  endtask

  task automatic chk_outs(input string tag, input logic valid, input logic [3:0] ipc,
                          input logic [15:0] instr, input logic [3:0] addr,
                          input logic bsy, input logic hlt);
    chk({tag, ".instr_valid"}, bus.instr_valid, valid);
    chk({tag, ".instr_pc"}, bus.instr_pc, ipc);
    chk({tag, ".instr"}, bus.instr, instr);
    chk({tag, ".rom_addr"}, bus.rom_addr, addr);
    chk({tag, ".busy"}, busy, bsy);
    chk({tag, ".halted"}, halted, hlt);
  endtask

  // Scoreboard of expected (pc, instr) handshakes
  typedef struct packed {
    logic [3:0]  pc;
    logic [15:0] instr;
  } hs_t;

  hs_t exp_q[$];
  hs_t mon_e;
  int  hs_cnt = 0;
  bit  mon_en = 1'b0;

  always @(negedge clk) begin
    if (mon_en && !rst && bus.instr_valid && bus.instr_ready) begin
      hs_cnt++;
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_handshake: got pc %0d instr %h, required none",
                 bus.instr_pc, bus.instr);
      end else begin
        mon_e = exp_q.pop_front();
        chk("hs.instr_pc", bus.instr_pc, mon_e.pc);
        chk("hs.instr", bus.instr, mon_e.instr);
      end
    end
  end

  typedef struct {
    string       name;
    logic        start, ready, jv;
    logic [3:0]  ja;
    logic        valid;
    logic [3:0]  ipc;
    logic [15:0] instr;
    logic [3:0]  addr;
    logic        bsy, hlt;
  } vec_t;

  function automatic vec_t mk(input string n, input logic s, input logic r, input logic j,
                              input logic [3:0] a, input logic v, input logic [3:0] p,
                              input logic [15:0] i, input logic [3:0] ad, input logic b,
                              input logic h);
    vec_t t;
    t.name = n; t.start = s; t.ready = r; t.jv = j; t.ja = a;
    t.valid = v; t.ipc = p; t.instr = i; t.addr = ad; t.bsy = b; t.hlt = h;
    return t;
  endfunction

  vec_t vecs[12];

  task automatic load_straight();
    for (int i = 0; i < 16; i++) rom[i] = 16'h0000;
    rom[0] = 16'hE102; rom[1] = 16'h4A05; rom[2] = 16'h1F01; rom[3] = 16'h9002;
  endtask

  // Leaves the bench at negedge+1 with rst released
  task automatic do_reset();
    rst = 1'b1; start = 1'b0;
    bus.instr_ready = 1'b0; bus.jump_valid = 1'b0; bus.jump_addr = '0;
    @(posedge clk);
    @(negedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic push_straight();
    exp_q.push_back('{pc: 4'd0, instr: 16'hE102});
    exp_q.push_back('{pc: 4'd1, instr: 16'h4A05});
    exp_q.push_back('{pc: 4'd2, instr: 16'h1F01});
    exp_q.push_back('{pc: 4'd3, instr: 16'h9002});
  endtask

  task automatic wait_halt(input string tag);
    for (int c = 0; c < 60 && !halted; c++) @(negedge clk);
    chk({tag, ".halt_reached"}, halted, 1'b1);
  endtask

  initial begin
    int edges;
    load_straight();

    vecs[0]  = mk("v0_start",     1, 0, 0, 0, 0, 0, 16'h0000, 0, 1, 0);
    vecs[1]  = mk("v1_issue",     0, 0, 0, 0, 1, 0, 16'hE102, 1, 1, 0);
    vecs[2]  = mk("v2_bp_jump",   0, 0, 1, 5, 1, 0, 16'hE102, 1, 1, 0);
    vecs[3]  = mk("v3_bp_start",  1, 0, 0, 0, 1, 0, 16'hE102, 1, 1, 0);
    vecs[4]  = mk("v4_accept_j3", 0, 1, 1, 3, 0, 0, 16'hE102, 3, 1, 0);
    vecs[5]  = mk("v5_fetch_j7",  0, 0, 1, 7, 1, 3, 16'h9002, 4, 1, 0);
    vecs[6]  = mk("v6_accept",    0, 1, 0, 0, 0, 3, 16'h9002, 4, 1, 0);
    vecs[7]  = mk("v7_halt",      0, 0, 0, 0, 0, 3, 16'h9002, 4, 0, 1);
    vecs[8]  = mk("v8_halt_jv",   0, 1, 1, 2, 0, 3, 16'h9002, 4, 0, 1);
    vecs[9]  = mk("v9_restart",   1, 0, 0, 0, 0, 3, 16'h9002, 0, 1, 0);
    vecs[10] = mk("v10_reissue",  0, 1, 0, 0, 1, 0, 16'hE102, 1, 1, 0);
    vecs[11] = mk("v11_hold",     0, 0, 0, 0, 1, 0, 16'hE102, 1, 1, 0);

    // Reset state
    rst = 1'b1; start = 1'b1;
    bus.instr_ready = 1'b0; bus.jump_valid = 1'b0; bus.jump_addr = '0;
    @(posedge clk);
    @(negedge clk);
    chk_outs("reset", 0, 0, 16'h0000, 0, 0, 0);
    #1 rst = 1'b0; start = 1'b0;

    // Table: backpressure, jump during accept, halt, restart from halt
    for (int k = 0; k < 12; k++) begin
      start = vecs[k].start;
      bus.instr_ready = vecs[k].ready;
      bus.jump_valid  = vecs[k].jv;
      bus.jump_addr   = vecs[k].ja;
      @(posedge clk);
      @(negedge clk);
      chk_outs(vecs[k].name, vecs[k].valid, vecs[k].ipc, vecs[k].instr, vecs[k].addr,
               vecs[k].bsy, vecs[k].hlt);
      #1;
    end

    // Straight-line run with ready held high; also latency from start
    do_reset();
    mon_en = 1'b1;
    push_straight();
    bus.instr_ready = 1'b1;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    edges = 1;
    while (!bus.instr_valid && edges < 10) begin
      @(posedge clk);
      #1 edges++;
    end
    chk("latency_edges", edges, 2);
    wait_halt("straight");
    repeat (3) @(negedge clk);
    chk("straight.rom_addr", bus.rom_addr, 4'd4);
    chk("straight.q_empty", exp_q.size(), 0);
    chk("straight.valid_low", bus.instr_valid, 1'b0);

    // Wrap: no halt word anywhere, 18 handshakes then stop accepting
    do_reset();
    for (int i = 0; i < 16; i++) rom[i] = 16'h1111;
    for (int i = 0; i < 18; i++) exp_q.push_back('{pc: 4'(i % 16), instr: 16'h1111});
    hs_cnt = 0;
    bus.instr_ready = 1'b1;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int c = 0; c < 80 && hs_cnt < 18; c++) begin
      @(negedge clk);
      #2;
    end
    @(posedge clk);
    #1 bus.instr_ready = 1'b0;
    chk("wrap.hs_count", hs_cnt, 18);
    chk("wrap.q_empty", exp_q.size(), 0);
    repeat (3) @(negedge clk);
    chk("wrap.halted", halted, 1'b0);
    chk("wrap.instr_pc", bus.instr_pc, 4'd2);

    // Reset mid-ISSUE, start ignored under reset, then clean restart
    load_straight();
    do_reset();
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("midrst.pre_valid", bus.instr_valid, 1'b1);
    #1 rst = 1'b1; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk_outs("midrst", 0, 0, 16'h0000, 0, 0, 0);
    @(posedge clk);
    @(negedge clk);
    chk("midrst.start_ignored_busy", busy, 1'b0);
    #1 rst = 1'b0; start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("midrst.idle_holds", busy, 1'b0);
    #1 push_straight();
    bus.instr_ready = 1'b1;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    wait_halt("midrst");
    chk("midrst.q_empty", exp_q.size(), 0);
    chk("midrst.rom_addr", bus.rom_addr, 4'd4);

    mon_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, required completion");
    $fatal(1);
  end

endmodule
